branch_predictor_btb: RTL and testbench



---
 rtl/branch_predictor_btb_pkg.sv | 13 +
 rtl/branch_predictor_btb_sat_counter.sv | 27 ++
 rtl/branch_predictor_btb.sv | 128 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and types for the branch target buffer.
// The entry layout lives in the top module because its field widths follow the top's parameters.
package branch_predictor_btb_pkg;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_HIT   = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_kind_t;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating counter next-value logic, shared by the entry counters and the statistics counters.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] value_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         set_max_i,
  input  logic         set_init_i,
  output logic [W-1:0] next_o
);

  always_comb begin
    next_o = value_i;
    if (set_max_i) begin
      next_o = '1;
    end else if (set_init_i) begin
      // Weakly taken: only the MSB set, which is also all ones when W = 1.
      next_o = W'(1) << (W - 1);
    end else if (inc_i) begin
      if (value_i != '1) next_o = value_i + W'(1);
    end else if (dec_i) begin
      if (value_i != '0) next_o = value_i - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational IF-stage lookup, registered ID-stage training.
// Each entry carries a saturating direction counter; update and miss statistics saturate.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_uncond,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } btb_entry_t;

  btb_entry_t        entries_q [ENTRIES];
  btb_entry_t        entries_d [ENTRIES];
  logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, wr_target;
  logic [CTR_W-1:0] ctr_next;
  upd_kind_t        upd_kind;
  logic             upd_pc_unused;

  assign lk_idx        = lookup_pc[IDX_W+1:2];
  assign lk_tag        = lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx        = upd_pc[IDX_W+1:2];
  assign up_tag        = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_pc_unused = ^upd_pc[1:0];

  assign pred_hit    = entries_q[lk_idx].valid && (entries_q[lk_idx].tag == lk_tag);
  assign pred_taken  = pred_hit && entries_q[lk_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? entries_q[lk_idx].target : lookup_pc + ADDR_W'(PC_INCR);

  assign up_hit = entries_q[up_idx].valid && (entries_q[up_idx].tag == up_tag);

  always_comb begin
    upd_kind = UPD_NONE;
    if (upd_valid && !clear) begin
      if (up_hit)         upd_kind = UPD_HIT;
      else if (upd_taken) upd_kind = UPD_ALLOC;
    end
  end

  // A not-taken hit only weakens the counter; the stored target is kept.
  assign wr_target = (upd_kind == UPD_ALLOC) ||
                     ((upd_kind == UPD_HIT) && (upd_taken || upd_uncond));

  sat_counter #(.W(CTR_W)) u_entry_ctr (
    .value_i    (entries_q[up_idx].ctr),
    .inc_i      ((upd_kind == UPD_HIT) && upd_taken),
    .dec_i      ((upd_kind == UPD_HIT) && !upd_taken),
    .set_max_i  ((upd_kind != UPD_NONE) && upd_uncond),
    .set_init_i (upd_kind == UPD_ALLOC),
    .next_o     (ctr_next)
  );

  sat_counter #(.W(STAT_W)) u_stat_upd (
    .value_i    (stat_upd_q),
    .inc_i      (upd_valid),
    .dec_i      (1'b0),
    .set_max_i  (1'b0),
    .set_init_i (1'b0),
    .next_o     (stat_upd_d)
  );

  sat_counter #(.W(STAT_W)) u_stat_mis (
    .value_i    (stat_mis_q),
    .inc_i      (upd_valid && (upd_pred_taken != upd_taken)),
    .dec_i      (1'b0),
    .set_max_i  (1'b0),
    .set_init_i (1'b0),
    .next_o     (stat_mis_d)
  );

  always_comb begin
    entries_d = entries_q;
    if (clear) begin
      for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
    end else if (upd_kind != UPD_NONE) begin
      entries_d[up_idx].valid  = 1'b1;
      entries_d[up_idx].tag    = up_tag;
      entries_d[up_idx].target = wr_target ? upd_target : entries_q[up_idx].target;
      entries_d[up_idx].ctr    = ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      entries_q  <= entries_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_updates = stat_upd_q;
  assign stat_mispred = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb against a table-level reference model.
module tb_branch_predictor_btb;

  localparam int ADDR_W   = 64;
  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int STAT_W   = 4;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] lookup_pc = '0;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic              upd_uncond = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic              clear = 1'b0;
  logic [STAT_W-1:0] stat_updates, stat_mispred;

  int checks = 0;
  int errors = 0;

  bit              m_valid [ENTRIES];
  bit [ADDR_W-1:0] m_tag   [ENTRIES];
  bit [ADDR_W-1:0] m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  int              m_upd, m_mis;

  branch_predictor_btb #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_uncond(upd_uncond), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .clear(clear),
    .stat_updates(stat_updates), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input bit [ADDR_W-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit [ADDR_W-1:0] m_tagof(input bit [ADDR_W-1:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_upd = 0; m_mis = 0;
  endfunction

  function automatic void model_lookup(input bit [ADDR_W-1:0] pc, output bit hit,
                                       output bit tk, output bit [ADDR_W-1:0] tgt);
    int i = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_ctr[i] >= CTR_HALF);
    tgt = tk ? m_tgt[i] : pc + 64'd4;
  endfunction

  function automatic void model_apply(input bit [ADDR_W-1:0] pc, input bit tk, input bit unc,
                                      input bit [ADDR_W-1:0] tgt, input bit pt, input bit clr);
    int i = m_idx(pc);
    if (m_upd < STAT_MAX) m_upd++;
    if (pt != tk && m_mis < STAT_MAX) m_mis++;
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      return;
    end
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (unc) begin
        m_ctr[i] = CTR_MAX; m_tgt[i] = tgt;
      end else if (tk) begin
        m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX; m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt;
      m_ctr[i] = unc ? CTR_MAX : CTR_HALF;
    end
  endfunction

  // Present one update (or a bare clear when vld = 0) across one rising edge.
  task automatic do_op(input bit vld, input bit [ADDR_W-1:0] pc, input bit tk, input bit unc,
                       input bit [ADDR_W-1:0] tgt, input bit pt, input bit clr);
    upd_valid = vld; upd_pc = pc; upd_taken = tk; upd_uncond = unc;
    upd_target = tgt; upd_pred_taken = pt; clear = clr;
    @(posedge clk);
    if (vld) model_apply(pc, tk, unc, tgt, pt, clr);
    else if (clr) for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    #1;
    upd_valid = 0; clear = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    lookup_pc = 64'h100;
    #2;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 64'h104) begin
      errors++;
      $display("FAIL reset_lookup: hit=%b taken=%b target=%h, required 0 0 104",
               pred_hit, pred_taken, pred_target);
    end
    checks++;
    if (stat_updates !== '0 || stat_mispred !== '0) begin
      errors++;
      $display("FAIL reset_stats: upd=%0d mis=%0d, required 0 0", stat_updates, stat_mispred);
    end
    lookup_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    checks++;
    if (pred_target !== 64'h0) begin
      errors++;
      $display("FAIL reset_wrap: target=%h, required 0", pred_target);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_train();
    bit eh, et;
    bit [ADDR_W-1:0] eg;
    lookup_pc = 64'h100;
    do_op(1, 64'h100, 1, 0, 64'h200, 0, 0);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h200) begin
      errors++;
      $display("FAIL alloc_lookup: hit=%b taken=%b target=%h, required 1 1 200",
               pred_hit, pred_taken, pred_target);
    end
    checks++;
    if (stat_mispred !== 4'd1 || stat_updates !== 4'd1) begin
      errors++;
      $display("FAIL alloc_stats: upd=%0d mis=%0d, required 1 1", stat_updates, stat_mispred);
    end
    for (int n = 0; n < 7; n++) begin
      bit tk = (n >= 3);
      do_op(1, 64'h100, tk, 0, 64'h200, pred_taken, 0);
      model_lookup(lookup_pc, eh, et, eg);
      checks++;
      if (pred_hit !== eh || pred_taken !== et || pred_target !== eg) begin
        errors++;
        $display("FAIL train_%0d: hit=%b taken=%b target=%h, required %b %b %h",
                 n, pred_hit, pred_taken, pred_target, eh, et, eg);
      end
      if (n == 0) begin
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 64'h104) begin
          errors++;
          $display("FAIL first_nt: taken=%b target=%h, required 0 104", pred_taken, pred_target);
        end
      end
    end
    checks++;
    if (m_ctr[m_idx(64'h100)] != CTR_MAX || stat_mispred !== 4'(m_mis)) begin
      errors++;
      $display("FAIL train_end: mis=%0d, required %0d", stat_mispred, m_mis);
    end
  endtask

  task automatic test_alias();
    lookup_pc = 64'h140;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 64'h144) begin
      errors++;
      $display("FAIL alias_miss: hit=%b target=%h, required 0 144", pred_hit, pred_target);
    end
    do_op(1, 64'h140, 1, 0, 64'h500, 0, 0);
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 64'h500) begin
      errors++;
      $display("FAIL alias_alloc: hit=%b target=%h, required 1 500", pred_hit, pred_target);
    end
    lookup_pc = 64'h100;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alias_evict: hit=%b taken=%b, required 0 0", pred_hit, pred_taken);
    end
  endtask

  task automatic test_same_cycle();
    do_op(0, 64'h0, 0, 0, 64'h0, 0, 1);
    lookup_pc = 64'h100;
    upd_valid = 1; upd_pc = 64'h100; upd_taken = 1; upd_uncond = 0;
    upd_target = 64'h240; upd_pred_taken = 1; clear = 0;
    #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_before: hit=%b, required 0", pred_hit);
    end
    @(posedge clk);
    model_apply(64'h100, 1, 0, 64'h240, 1, 0);
    #1;
    upd_valid = 0;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 64'h240) begin
      errors++;
      $display("FAIL same_cycle_after: hit=%b target=%h, required 1 240", pred_hit, pred_target);
    end
    do_op(1, 64'h100, 1, 1, 64'h300, 1, 1);
    checks++;
    if (pred_hit !== 1'b0 || stat_updates !== 4'(m_upd)) begin
      errors++;
      $display("FAIL clear_with_upd: hit=%b upd=%0d, required 0 %0d",
               pred_hit, stat_updates, m_upd);
    end
  endtask

  task automatic test_random();
    bit [ADDR_W-1:0] pool [12];
    bit eh, et;
    bit [ADDR_W-1:0] eg;
    int bad = 0;
    for (int i = 0; i < 11; i++)
      pool[i] = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 3)) << 2);
    pool[11] = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int n = 0; n < 300; n++) begin
      lookup_pc = pool[$urandom_range(0, 11)];
      #1;
      model_lookup(lookup_pc, eh, et, eg);
      checks++;
      if (pred_hit !== eh || pred_taken !== et || pred_target !== eg) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_lookup_%0d: pc=%h hit=%b taken=%b target=%h, required %b %b %h",
                   n, lookup_pc, pred_hit, pred_taken, pred_target, eh, et, eg);
      end
      do_op($urandom_range(0, 5) != 0, pool[$urandom_range(0, 11)], 1'($urandom),
            $urandom_range(0, 5) == 0, {$urandom, $urandom_range(0, 255), 2'b00} & 64'hFFFF_FFFF_FFFC,
            1'($urandom), $urandom_range(0, 40) == 0);
      checks++;
      if (stat_updates !== 4'(m_upd) || stat_mispred !== 4'(m_mis)) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_stats_%0d: upd=%0d mis=%0d, required %0d %0d",
                   n, stat_updates, stat_mispred, m_upd, m_mis);
      end
    end
  endtask

  task automatic test_async_reset_and_stats();
    do_op(1, 64'h100, 1, 1, 64'h700, 1, 0);
    lookup_pc = 64'h100;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 64'h104 ||
        stat_updates !== '0 || stat_mispred !== '0) begin
      errors++;
      $display("FAIL async_reset: hit=%b taken=%b target=%h upd=%0d mis=%0d, required 0 0 104 0 0",
               pred_hit, pred_taken, pred_target, stat_updates, stat_mispred);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(1, 64'h100, 1, 0, 64'h800, 0, 0);
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 64'h800 || stat_updates !== 4'd1) begin
      errors++;
      $display("FAIL first_after_release: hit=%b target=%h upd=%0d, required 1 800 1",
               pred_hit, pred_target, stat_updates);
    end
    for (int n = 0; n < 20; n++) begin
      do_op(1, 64'h180, 1, 0, 64'h900, 0, 0);
      checks++;
      if (stat_mispred !== 4'(m_mis)) begin
        errors++;
        $display("FAIL mispred_sat_%0d: mis=%0d, required %0d", n, stat_mispred, m_mis);
      end
    end
    checks++;
    if (stat_mispred !== 4'd15 || stat_updates !== 4'd15) begin
      errors++;
      $display("FAIL stat_hold: upd=%0d mis=%0d, required 15 15", stat_updates, stat_mispred);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_same_cycle();
    test_random();
    test_async_reset_and_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
